// File: rtl/exec_alu_unit_if.sv
// EX-stage ALU interface: issue side (valid/flush/control/operands) and result side.
interface exec_alu_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic            flush;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            busy;
    logic            done;

    modport master (
        output valid, flush, alu_control, src_a, src_b,
        input  alu_result, zero, busy, done
    );

    modport slave (
        input  valid, flush, alu_control, src_a, src_b,
        output alu_result, zero, busy, done
    );
endinterface

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU with a one-bit-per-cycle serial shifter for non-zero shift amounts.
// Define FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module exec_alu_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    exec_alu_unit_if.slave alu
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpSll  = 4'b0100;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpXor  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;

    logic [4:0]      shamt;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            done;

    assign shamt = alu.src_b[4:0];

    always_comb begin
        comb_res = '0;
        case (alu.alu_control)
            OpAdd:  comb_res = alu.src_a + alu.src_b;
            OpSub:  comb_res = alu.src_a - alu.src_b;
            OpAnd:  comb_res = alu.src_a & alu.src_b;
            OpOr:   comb_res = alu.src_a | alu.src_b;
            OpXor:  comb_res = alu.src_a ^ alu.src_b;
            OpSlt:  comb_res = {{(XLEN-1){1'b0}}, $signed(alu.src_a) < $signed(alu.src_b)};
            OpSltu: comb_res = {{(XLEN-1){1'b0}}, alu.src_a < alu.src_b};
`ifdef FAST_SHIFT_EN
            OpSll:  comb_res = alu.src_a << shamt;
            OpSrl:  comb_res = alu.src_a >> shamt;
            OpSra:  comb_res = $unsigned($signed(alu.src_a) >>> shamt);
`else
            // Combinational path only serves shamt == 0; longer shifts go serial.
            OpSll, OpSrl, OpSra: comb_res = alu.src_a;
`endif
            default: comb_res = '0;
        endcase
    end

`ifdef FAST_SHIFT_EN
    always_comb begin
        result = '0;
        busy   = 1'b0;
        done   = 1'b0;
        if (!rst && !alu.flush && alu.valid) begin
            result = comb_res;
            done   = 1'b1;
        end
    end
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q;
    logic [XLEN-1:0] sreg_q;
    logic [4:0]      cnt_q;
    logic            left_q;
    logic            arith_q;
    logic            is_shift;
    logic            start;

    assign is_shift = (alu.alu_control == OpSll) || (alu.alu_control == OpSrl) ||
                      (alu.alu_control == OpSra);
    assign start    = alu.valid && is_shift && (shamt != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (alu.flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sreg_q  <= alu.src_a;
                        cnt_q   <= shamt;
                        left_q  <= (alu.alu_control == OpSll);
                        arith_q <= (alu.alu_control == OpSra);
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (left_q) begin
                        sreg_q <= {sreg_q[XLEN-2:0], 1'b0};
                    end else begin
                        sreg_q <= {arith_q & sreg_q[XLEN-1], sreg_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        result = '0;
        busy   = 1'b0;
        done   = 1'b0;
        // Reset and flush both present as an idle, empty stage this cycle.
        if (!rst && !alu.flush) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy = 1'b1;
                    end else if (alu.valid) begin
                        result = comb_res;
                        done   = 1'b1;
                    end
                end
                StShift: busy = 1'b1;
                StDone: begin
                    result = sreg_q;
                    done   = 1'b1;
                end
                default: ;
            endcase
        end
    end
`endif

    assign alu.alu_result = result;
    assign alu.busy       = busy;
    assign alu.done       = done;
    assign alu.zero       = (result == '0);

endmodule

// File: doc/exec_alu_unit.md
# exec_alu_unit

Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder together with the two EX-stage operands and produces ALUResult/Zero for the EX/MEM register. Non-shift operations complete in the issue cycle; SLL/SRL/SRA with a non-zero shift amount run on an area-saving serial shifter (one bit per cycle). While a serial shift is in flight, Busy tells the hazard unit to stall IF/ID/EX.

## Interface
- XLEN, 32, datapath width (shift amount field is SrcB[4:0], fixed for XLEN=32)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- Valid  input  1  EX stage holds a real instruction this cycle
- Flush  input  1  hazard-unit flush of EX; kills any in-flight shift
- ALUControl  input  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt, 0110 srl, 0111 sra, 1000 xor, 1001 sltu; others → result 0
- SrcA  input  XLEN  operand A
- SrcB  input  XLEN  operand B
- ALUResult  output  XLEN  result
- Zero  output  1  ALUResult == 0
- Busy  output  1  stall request to hazard unit
- Done  output  1  ALUResult valid for the current instruction this cycle

## Operation
- States: IDLE, SHIFT, DONE. Internal: shift register sreg[XLEN-1:0], counter cnt[4:0], latched direction/arith bits.
- IDLE, Valid=0: ALUResult=0, Zero=1, Busy=0, Done=0.
- IDLE, Valid=1, non-shift op, or shift op with SrcB[4:0]=0: ALUResult combinational from SrcA/SrcB, Done=1, Busy=0; stay IDLE.
- IDLE, Valid=1, shift op, n=SrcB[4:0]≥1, Flush=0: Busy=1, Done=0, ALUResult=0 this cycle; at edge sreg←SrcA, cnt←n, latch op, go SHIFT.
- SHIFT: each edge shifts sreg one bit (SLL: left, zero fill; SRL: right, zero fill; SRA: right, replicate sreg[XLEN-1]), cnt←cnt-1; on the edge where cnt==1, go DONE. Busy=1, Done=0, ALUResult=0. Inputs ignored (held by stall).
- DONE: ALUResult=sreg, Done=1, Busy=0; inputs ignored; next edge → IDLE.
- Arithmetic: add/sub modulo 2^XLEN; slt signed compare, sltu unsigned, result 0 or 1 zero-extended.
- Flush=1 in any state: Busy=0, Done=0, ALUResult=0 this cycle; next state IDLE. Flush overrides Valid.
- rst=1: next state IDLE, sreg=0, cnt=0; during the reset cycle, outputs as for IDLE with Valid=0 regardless of inputs.

## Timing
- Single-cycle ops: zero latency (combinational issue → result).
- Serial shift of n (1..31) issued in cycle k: Busy high cycles k..k+n (n+1 cycles), Done/result in cycle k+n+1, unit IDLE at k+n+2 and can accept a new op that cycle.
- Back-to-back: a new Valid op in cycle k+n+2 is processed normally; no dead cycle beyond DONE.
- Reset mid-shift: shift abandoned, no Done ever produced for it.
- Zero is always combinational from ALUResult.

## Configuration
- FAST_SHIFT_EN defined: single-cycle barrel shifter; all ops complete in the issue cycle; FSM, sreg, cnt absent; Busy tied 0; Done=Valid&~Flush.
- FAST_SHIFT_EN undefined: serial shifter and FSM as described above.

## Test plan
- Reset, then Valid=1, ALUControl=0001, SrcA=5, SrcB=5 → same cycle ALUResult=0, Zero=1, Done=1, Busy=0.
- ALUControl=0111, SrcA=0x8000_0000, SrcB=4 issued cycle k, inputs held → Busy=1 cycles k..k+4, cycle k+5 ALUResult=0xF800_0000, Done=1; with FAST_SHIFT_EN same result at cycle k, Busy never 1.
- ALUControl=0100, SrcA=1, SrcB=0x20 (shamt 0) → single cycle ALUResult=1, Busy=0.
- ALUControl=0101 SrcA=0xFFFF_FFFF SrcB=1 → 1; ALUControl=1001 same operands → 0.
- SRL SrcA=0xF0, SrcB=31, assert Flush in 3rd SHIFT cycle → Busy=0 that cycle, IDLE next, no Done; following add 2+3 → 5 immediately.
- SLL shamt 10 in flight, rst=1 one cycle → IDLE, Busy=0, Done never asserted for that op.
